// File: rtl/eth_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_ctrl_pkg
// Description : Shared constants and types for the Ethernet control CSR path.
//               The command bit positions are also used by the upstream CSR
//               block and the software driver.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_ctrl_pkg;

  // Command bit positions inside the 32-bit control/address register
  localparam int ETH_CMD_WR_BIT = 16;
  localparam int ETH_CMD_RD_BIT = 17;

  // Default transaction timeout and the read data reported on a timed-out read
  localparam int          ETH_DEF_TIMEOUT_CYCLES = 1024;
  localparam logic [31:0] ETH_DEF_TIMEOUT_RDATA  = 32'hFFFF_FFFF;

  // Bridge state encodings, kept as plain constants for legacy tooling
  localparam logic [1:0] ETH_ST_IDLE    = 2'd0;
  localparam logic [1:0] ETH_ST_WR      = 2'd1;
  localparam logic [1:0] ETH_ST_RD_REQ  = 2'd2;
  localparam logic [1:0] ETH_ST_RD_WAIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ETH_ST_IDLE,
    WR      = ETH_ST_WR,
    RD_REQ  = ETH_ST_RD_REQ,
    RD_WAIT = ETH_ST_RD_WAIT
  } t_eth_bridge_state;

  // Command level pair as seen on the control register
  typedef struct packed {
    logic rd;
    logic wr;
  } t_eth_cmd;

  // Extract the read/write command levels from the control register
  function automatic t_eth_cmd eth_cmd_from_ctrl(input logic [31:0] ctrl);
    t_eth_cmd cmd;
    cmd.rd = ctrl[ETH_CMD_RD_BIT];
    cmd.wr = ctrl[ETH_CMD_WR_BIT];
    return cmd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_ctrl_avmm_bridge_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : eth_cmd_edge_det
// Description : Rising-edge detector for the read/write command bits plus
//               collision qualification. A command is only "go" when the
//               bridge is idle and exactly one command bit rose this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_cmd_edge_det
  import eth_ctrl_pkg::*;
(
  input  logic     pClkDiv4,
  input  logic     pck_cp2af_softReset_T1,
  input  t_eth_cmd cmd_i,
  input  logic     idle_i,
  output logic     wr_go_o,
  output logic     rd_go_o,
  output logic     collision_o
);

  t_eth_cmd cmd_q;
  t_eth_cmd cmd_d;
  logic     rise_wr;
  logic     rise_rd;

  assign cmd_d = cmd_i;

  // Remember last cycle's command levels so a held level does not re-trigger
  always_ff @(posedge pClkDiv4 or posedge pck_cp2af_softReset_T1) begin
    if (pck_cp2af_softReset_T1) begin
      cmd_q <= '0;
    end else begin
      cmd_q <= cmd_d;
    end
  end

  assign rise_wr = cmd_i.wr & ~cmd_q.wr;
  assign rise_rd = cmd_i.rd & ~cmd_q.rd;

  // A lone edge while idle starts a transaction
  assign wr_go_o = idle_i & rise_wr & ~rise_rd;
  assign rd_go_o = idle_i & rise_rd & ~rise_wr;

  // Any edge while busy, or both edges at once, is dropped and flagged
  assign collision_o = (rise_wr | rise_rd) & (~idle_i | (rise_wr & rise_rd));

endmodule
`default_nettype wire

// File: rtl/eth_ctrl_avmm_bridge.sv
`default_nettype none
// ============================================================================
// Module      : eth_ctrl_avmm_bridge
// Description : Turns edges on the Ethernet control register command bits
//               into single-beat Avalon-MM reads/writes on the HSSI CSR bus.
//               Every transaction is bounded by a timeout so a hung slave
//               cannot lock up the host; errors are sticky until reset.
//               All outputs come straight from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_ctrl_avmm_bridge
  import eth_ctrl_pkg::*;
#(
  // Address width must stay below the command bits (ADDR_W <= 16)
  parameter int          ADDR_W         = 16,
  parameter int          TIMEOUT_CYCLES = ETH_DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] TIMEOUT_RDATA  = ETH_DEF_TIMEOUT_RDATA
) (
  input  logic              pClkDiv4,
  input  logic              pck_cp2af_softReset_T1,
  input  logic [31:0]       eth_ctrl_addr,
  input  logic [31:0]       eth_wr_data,
  output logic [31:0]       eth_rd_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_collision
);

  // Counter holds 0..TIMEOUT_CYCLES; the top value is only ever a next-state
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  t_eth_bridge_state state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_to_q, err_to_d;
  logic              err_col_q, err_col_d;

  logic              wr_go;
  logic              rd_go;
  logic              collision;
  logic              idle;
  logic              done;

  // Only the command bits and the low address bits are consumed
  logic              unused_ctrl;
  assign unused_ctrl = &{1'b0, eth_ctrl_addr};

  assign idle = (state_q == IDLE);

  eth_cmd_edge_det u_edge_det (
    .pClkDiv4               (pClkDiv4),
    .pck_cp2af_softReset_T1 (pck_cp2af_softReset_T1),
    .cmd_i                  (eth_cmd_from_ctrl(eth_ctrl_addr)),
    .idle_i                 (idle),
    .wr_go_o                (wr_go),
    .rd_go_o                (rd_go),
    .collision_o            (collision)
  );

  // Next-state: command accept, Avalon handshake, timeout abort, error flags
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_to_d  = err_to_q;
    err_col_d = err_col_q | collision;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (wr_go || rd_go) begin
          addr_d  = eth_ctrl_addr[ADDR_W-1:0];
          wdata_d = eth_wr_data;
          state_d = wr_go ? WR : RD_REQ;
        end
      end
      WR: begin
        done = ~avm_waitrequest;
      end
      RD_REQ: begin
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            rdata_d = avm_readdata;
            done    = 1'b1;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          rdata_d = avm_readdata;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A handshake that completes on the last allowed cycle still counts as
    // a completion; otherwise the last cycle aborts the transaction.
    if (!idle) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (done) begin
        state_d = IDLE;
      end else if (cnt_q == CNT_LAST) begin
        state_d  = IDLE;
        err_to_d = 1'b1;
        if (state_q != WR) begin
          rdata_d = TIMEOUT_RDATA;
        end
      end
    end
  end

  // State and datapath registers; reset drops strobes and clears read data at once
  always_ff @(posedge pClkDiv4 or posedge pck_cp2af_softReset_T1) begin
    if (pck_cp2af_softReset_T1) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_to_q  <= 1'b0;
      err_col_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_to_q  <= err_to_d;
      err_col_q <= err_col_d;
    end
  end

  assign avm_write     = (state_q == WR);
  assign avm_read      = (state_q == RD_REQ);
  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign eth_rd_data   = rdata_q;
  assign busy          = ~idle;
  assign err_timeout   = err_to_q;
  assign err_collision = err_col_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_ctrl_avmm_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_eth_ctrl_avmm_bridge
// Description : Self-checking bench for eth_ctrl_avmm_bridge: directed
//               scenarios with literal expectations, then randomized traffic
//               compared every cycle against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_ctrl_avmm_bridge;

  localparam int          ADDR_W   = 16;
  localparam int          TO       = 16;
  localparam logic [31:0] TO_RDATA = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       ctrl = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata_in = '0;
  logic              valid = 1'b0;
  logic              waitreq = 1'b0;

  logic [31:0]       eth_rd_data;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic              avm_read;
  logic [31:0]       avm_writedata;
  logic              busy;
  logic              err_timeout;
  logic              err_collision;

  int total = 0;
  int bad   = 0;

  eth_ctrl_avmm_bridge #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_RDATA  (TO_RDATA)
  ) dut (
    .pClkDiv4               (clk),
    .pck_cp2af_softReset_T1 (rst),
    .eth_ctrl_addr          (ctrl),
    .eth_wr_data            (wdata),
    .eth_rd_data            (eth_rd_data),
    .avm_address            (avm_address),
    .avm_write              (avm_write),
    .avm_read               (avm_read),
    .avm_writedata          (avm_writedata),
    .avm_readdata           (rdata_in),
    .avm_readdatavalid      (valid),
    .avm_waitrequest        (waitreq),
    .busy                   (busy),
    .err_timeout            (err_timeout),
    .err_collision          (err_collision)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction-level reference model. One outstanding transaction at most;
  // it remembers whether it is a read, whether the read request has been
  // accepted by the slave, and how many cycles it has been alive.
  // --------------------------------------------------------------------------
  bit          m_active = 0;
  bit          m_read   = 0;
  bit          m_accepted = 0;
  int          m_age    = 0;
  logic [15:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  logic [31:0] m_rdata  = '0;
  bit          m_to     = 0;
  bit          m_col    = 0;
  bit          m_prev_wr = 0;
  bit          m_prev_rd = 0;

  always @(posedge clk or posedge rst) begin : model
    bit rise_wr, rise_rd, finished;
    if (rst) begin
      m_active = 0; m_read = 0; m_accepted = 0; m_age = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      m_to = 0; m_col = 0; m_prev_wr = 0; m_prev_rd = 0;
    end else begin
      rise_wr   = ctrl[16] && !m_prev_wr;
      rise_rd   = ctrl[17] && !m_prev_rd;
      m_prev_wr = ctrl[16];
      m_prev_rd = ctrl[17];
      if (!m_active) begin
        if (rise_wr && rise_rd) begin
          m_col = 1;
        end else if (rise_wr || rise_rd) begin
          m_active   = 1;
          m_read     = rise_rd;
          m_accepted = 0;
          m_age      = 0;
          m_addr     = ctrl[15:0];
          m_wdata    = wdata;
        end
      end else begin
        if (rise_wr || rise_rd) m_col = 1;
        finished = 0;
        if (!m_read) begin
          finished = !waitreq;
        end else if (!m_accepted) begin
          if (!waitreq) begin
            if (valid) begin
              m_rdata  = rdata_in;
              finished = 1;
            end else begin
              m_accepted = 1;
            end
          end
        end else if (valid) begin
          m_rdata  = rdata_in;
          finished = 1;
        end
        if (!finished && m_age == TO - 1) begin
          m_to = 1;
          if (m_read) m_rdata = TO_RDATA;
          finished = 1;
        end
        if (finished) m_active = 0;
        else m_age++;
      end
    end
  end

  // Every cycle, on the falling edge, all outputs must match the model
  always @(negedge clk) begin
    check1 ("cyc_busy",      busy,          m_active);
    check1 ("cyc_avm_write", avm_write,     m_active && !m_read);
    check1 ("cyc_avm_read",  avm_read,      m_active && m_read && !m_accepted);
    check32("cyc_address",   32'(avm_address), 32'(m_addr));
    check32("cyc_writedata", avm_writedata, m_wdata);
    check32("cyc_rd_data",   eth_rd_data,   m_rdata);
    check1 ("cyc_err_to",    err_timeout,   m_to);
    check1 ("cyc_err_col",   err_collision, m_col);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ctrl = '0; valid = 1'b0; waitreq = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  initial begin : stim
    int cnt;
    int hang_left;
    int r;

    repeat (3) @(posedge clk);
    #1;
    // Reset values
    check1 ("rst_busy",   busy, 1'b0);
    check1 ("rst_write",  avm_write, 1'b0);
    check1 ("rst_read",   avm_read, 1'b0);
    check32("rst_rdata",  eth_rd_data, 32'h0);
    check1 ("rst_err_to", err_timeout, 1'b0);
    check1 ("rst_err_col", err_collision, 1'b0);
    rst = 1'b0;
    step();

    // Zero-wait write
    ctrl = 32'h0001_0123; wdata = 32'hA5A5_0001; waitreq = 1'b0;
    step();
    check1 ("wr_strobe",  avm_write, 1'b1);
    check32("wr_addr",    32'(avm_address), 32'h0000_0123);
    check32("wr_data",    avm_writedata, 32'hA5A5_0001);
    check1 ("wr_busy1",   busy, 1'b1);
    step();
    check1 ("wr_strobe_off", avm_write, 1'b0);
    check1 ("wr_busy2",   busy, 1'b0);
    check1 ("wr_no_err",  err_timeout | err_collision, 1'b0);
    ctrl = '0;
    step();

    // Read: 3 extra waitrequest cycles, readdatavalid 5 cycles after accept
    ctrl = 32'h0002_0040; waitreq = 1'b1; cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (avm_read) cnt++;
      if (c == 1) ctrl = '0;
      waitreq  = (c < 4);
      valid    = (c == 9);
      rdata_in = (c == 9) ? 32'h1234_5678 : $urandom();
      if (c == 9) check32("rd_data_before", eth_rd_data, 32'h0);
    end
    check32("rd_strobe_cycles", cnt, 4);
    check32("rd_data",   eth_rd_data, 32'h1234_5678);
    check1 ("rd_busy",   busy, 1'b0);
    valid = 1'b0;
    step();

    // Hung slave on a read
    ctrl = 32'h0002_0077; waitreq = 1'b1; cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (avm_read) cnt++;
      if (c == 1) ctrl = '0;
      if (c == 16) check1("to_not_yet", err_timeout, 1'b0);
      if (c == 17) check1("to_set", err_timeout, 1'b1);
    end
    check32("to_strobe_cycles", cnt, TO);
    check32("to_rdata", eth_rd_data, 32'hFFFF_FFFF);
    waitreq = 1'b0; ctrl = 32'h0001_0200; wdata = 32'hDEAD_BEEF;
    step();
    check1 ("to_next_wr", avm_write, 1'b1);
    check32("to_next_addr", 32'(avm_address), 32'h0000_0200);
    step();
    check1 ("to_next_idle", busy, 1'b0);
    check1 ("to_sticky", err_timeout, 1'b1);
    ctrl = '0;
    step();

    // Simultaneous rd/wr edges
    do_reset();
    ctrl = 32'h0003_0011; cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (avm_write || avm_read) cnt++;
    end
    check32("col_no_strobe", cnt, 0);
    check1 ("col_flag", err_collision, 1'b1);
    check1 ("col_idle", busy, 1'b0);

    // New rd edge during an outstanding read
    do_reset();
    waitreq = 1'b1; ctrl = 32'h0002_0005;
    step();
    ctrl = '0;
    step();
    ctrl = 32'h0002_0006;
    step();
    check1 ("busy_col_flag", err_collision, 1'b1);
    check32("busy_col_addr", 32'(avm_address), 32'h0000_0005);
    waitreq = 1'b0; valid = 1'b1; rdata_in = 32'hCAFE_0001;
    step();
    valid = 1'b0; ctrl = '0;
    check32("busy_col_rdata", eth_rd_data, 32'hCAFE_0001);
    check1 ("busy_col_done", busy, 1'b0);
    step();

    // Level held for 10 cycles issues one write
    waitreq = 1'b0; ctrl = 32'h0001_0033; cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (avm_write) cnt++;
      if (c == 10) ctrl = '0;
    end
    check32("held_one_write", cnt, 1);

    // Stray readdatavalid while idle
    valid = 1'b1; rdata_in = 32'h5555_AAAA;
    step(); step(); step();
    valid = 1'b0;
    check32("stray_rdata", eth_rd_data, 32'hCAFE_0001);

    // Reset while waiting for read data
    ctrl = 32'h0002_0009; waitreq = 1'b0; valid = 1'b0;
    step();
    ctrl = '0;
    step();
    check1 ("rw_busy", busy, 1'b1);
    check1 ("rw_read_off", avm_read, 1'b0);
    rst = 1'b1;
    #1;
    check1 ("rstmid_read", avm_read, 1'b0);
    check1 ("rstmid_write", avm_write, 1'b0);
    check1 ("rstmid_busy", busy, 1'b0);
    check32("rstmid_rdata", eth_rd_data, 32'h0);
    step();
    rst = 1'b0; valid = 1'b1; rdata_in = 32'h7777_0000;
    step(); step();
    valid = 1'b0;
    check32("late_valid_rdata", eth_rd_data, 32'h0);
    check1 ("late_valid_busy", busy, 1'b0);

    // Randomized traffic, checked every cycle by the model
    hang_left = 0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (hang_left > 0) begin
        waitreq = 1'b1;
        valid   = 1'b0;
        hang_left--;
      end else begin
        waitreq = ($urandom_range(0, 1) == 1);
        valid   = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 60) == 0) hang_left = $urandom_range(10, 24);
      end
      rdata_in = $urandom();
      r = $urandom_range(0, 9);
      if (r == 0) ctrl[16] = ~ctrl[16];
      else if (r == 1) ctrl[17] = ~ctrl[17];
      else if (r == 2) ctrl[17:16] = ~ctrl[17:16];
      ctrl[15:0]  = 16'($urandom());
      ctrl[31:18] = 14'($urandom());
      wdata       = $urandom();
      rst = ($urandom_range(0, 700) == 0);
    end
    rst = 1'b0; ctrl = '0; valid = 1'b0; waitreq = 1'b0;
    repeat (TO + 4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
